shift_add_multiplier: RTL and testbench
=======================================

# shift_add_multiplier

Multi-cycle unsigned radix-2 shift-and-add multiplier that sits directly upstream of the 32-bit carry-look-ahead adder. Each cycle it drives the adder's augend and addend with the running partial product and the shifted multiplicand, then registers the adder's sum. It gives the RISC datapath a MUL operation without a dedicated array multiplier, reusing one combinational 32-bit adder instance.

## Interface
- WIDTH, 16: operand width. Legal range 2..16, so that 2*WIDTH ≤ 32.
- EARLY_EXIT, 0: when 1, finish as soon as all remaining multiplier bits are zero.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request a multiply; sampled only when busy=0.
- multiplicand  input  WIDTH  operand A, latched when start is accepted.
- multiplier  input  WIDTH  operand B, latched when start is accepted.
- add_augend  output  32  to adder augend: the current partial product.
- add_addend  output  32  to adder addend: the shifted multiplicand or zero.
- add_cin  output  1  to adder cin; constant 0.
- add_sum  input  32  from adder sum, combinational in the same cycle.
- add_carry  input  1  from adder carry.
- busy  output  1  high while iterating.
- done  output  1  one-cycle pulse when product becomes valid.
- product  output  2*WIDTH  result; holds its value until the next done.
- ovf  output  1  sticky; set if add_carry=1 on any accumulate. Cleared on start accept and on reset.

## Operation
- States: IDLE, CALC, DONE. State encoding is free.
- **IDLE:** busy=0.
  - start=1 latches A and B, clears acc (32b) and count, clears ovf, and moves to CALC.
- **CALC:** busy=1. Each cycle:
  - add_augend=acc.
  - add_addend = B[count] ? zero-extended A << count : 0.
  - acc <= add_sum.
  - ovf |= add_carry & B[count].
  - count increments.
  - Exit to DONE after the edge where count==WIDTH-1.
  - With EARLY_EXIT=1, also exit after any edge where B >> (count+1) == 0.
  - On that exit edge, product <= add_sum[2*WIDTH-1:0].
- **DONE:** done=1 and busy=0 for exactly one cycle. Next state is IDLE, or CALC if start=1 in this cycle, in which case new operands are latched.
- In IDLE and DONE, add_augend=0 and add_addend=0, so the adder output is don't-care.
- start while busy=1 is ignored, with no queuing.
- Operand inputs may change freely after acceptance; only the latched copies are used.
- Arithmetic is unsigned modulo 2^32. For WIDTH ≤ 16, ovf can never legally set; it exists as a checker for a broken adder.
- Reset (asynchronous, any state):
  - State=IDLE; busy=0, done=0, product=0, ovf=0, acc=0, count=0.
  - add_augend=0, add_addend=0, add_cin=0.
  - An in-flight operation is aborted with no done pulse, and product stays 0.

## Timing
- start accepted at edge E0 → busy=1 from E0.
- Iterations occur at E1..E(WIDTH) → done=1 and product valid from E(WIDTH) until E(WIDTH+1).
- Latency from accept to done is WIDTH cycles (16 at default). With EARLY_EXIT=1 it is 1..WIDTH cycles; B=0 gives 1 cycle.
- Maximum throughput is one multiply per WIDTH+1 cycles, using back-to-back start in the DONE cycle.
- The adder path add_augend/add_addend → add_sum → acc is a single-cycle combinational path; no internal pipelining.
- done never asserts in the same cycle as busy.
- product changes only on the edge that raises done.

## Test plan
- **Basic multiply:** A=3, B=5, start for 1 cycle → done exactly 16 cycles after accept, product=32'h0000000F, ovf=0.
- **Maximum operands:** A=16'hFFFF, B=16'hFFFF → product=32'hFFFE0001, ovf=0. Bench checks add_addend=32'hFFFF<<k on every iteration k.
- **Start during busy:** start at cycles 0 and 5 with A=7, B=9, then A=2, B=2 at cycle 5 → a single done with product=63. No second operation begins.
- **Back-to-back:** start held high from cycle 0 → a new operation is accepted in each DONE cycle, giving done every 17 cycles with the correct product each time.
- **Reset mid-operation:** rst_n low at iteration 8 of A=100, B=200 → all outputs 0 immediately. After release, A=100, B=200 yields product=20000.
- **Early exit (EARLY_EXIT=1):**
  - B=1, A=16'h1234 → done 1 cycle after accept, product=32'h00001234.
  - B=0 → done after 1 cycle, product=0.

Source files
------------

// File: rtl/shift_add_multiplier.sv
// Radix-2 shift-and-add multiplier that borrows an external 32-bit adder:
// one multiplier bit per cycle, the partial product is accumulated through add_sum.
module shift_add_multiplier #(
    parameter int WIDTH      = 16,
    parameter bit EARLY_EXIT = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic [31:0]          add_augend,
    output logic [31:0]          add_addend,
    output logic                 add_cin,
    input  logic [31:0]          add_sum,
    input  logic                 add_carry,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic                 ovf
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] b_shift;
    logic [31:0]      acc;
    logic [CW-1:0]    count;
    logic             accept;
    logic             cur_bit;
    logic             last_iter;

    // b_shift exposes the current multiplier bit in bit 0; what remains above it
    // decides whether an early exit is possible.
    always_comb begin
        b_shift   = b_reg >> count;
        cur_bit   = b_shift[0];
        last_iter = (count == CW'(WIDTH - 1)) ||
                    (EARLY_EXIT && ((b_shift >> 1) == '0));
        accept    = start && (state != CALC);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (last_iter) state_next = DONE;
            DONE:    state_next = start ? CALC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy       = (state == CALC);
        done       = (state == DONE);
        add_cin    = 1'b0;
        add_augend = '0;
        add_addend = '0;
        if (state == CALC) begin
            add_augend = acc;
            if (cur_bit) add_addend = 32'(a_reg) << count;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            acc     <= '0;
            count   <= '0;
            ovf     <= 1'b0;
            product <= '0;
        end else if (accept) begin
            a_reg <= multiplicand;
            b_reg <= multiplier;
            acc   <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else if (state == CALC) begin
            acc   <= add_sum;
            count <= count + CW'(1);
            ovf   <= ovf | (add_carry & cur_bit);
            if (last_iter) product <= add_sum[2*WIDTH-1:0];
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier: a behavioural adder closes the loop for a
// full-length instance and an early-exit instance.
module tb_shift_add_multiplier;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_m = 1'b0;
    logic        start_e = 1'b0;
    logic [15:0] mcand = '0;
    logic [15:0] mplier = '0;
    logic        inject = 1'b0;
    logic        use_ee = 1'b0;

    logic [31:0] aug_m, addend_m, sum_m, prod_m;
    logic        cin_m, carry_m, busy_m, done_m, ovf_m;
    logic [31:0] aug_e, addend_e, sum_e, prod_e;
    logic        cin_e, carry_e, busy_e, done_e, ovf_e;
    logic [32:0] full_m, full_e;
    logic        cur_done, cur_busy, cur_ovf;
    logic [31:0] cur_prod;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign full_m  = {1'b0, aug_m} + {1'b0, addend_m} + {32'b0, cin_m};
    assign sum_m   = full_m[31:0];
    assign carry_m = full_m[32] | inject;
    assign full_e  = {1'b0, aug_e} + {1'b0, addend_e} + {32'b0, cin_e};
    assign sum_e   = full_e[31:0];
    assign carry_e = full_e[32];

    assign cur_done = use_ee ? done_e : done_m;
    assign cur_busy = use_ee ? busy_e : busy_m;
    assign cur_ovf  = use_ee ? ovf_e  : ovf_m;
    assign cur_prod = use_ee ? prod_e : prod_m;

    shift_add_multiplier #(.WIDTH(16), .EARLY_EXIT(1'b0)) u_mul (
        .clk(clk), .rst_n(rst_n), .start(start_m),
        .multiplicand(mcand), .multiplier(mplier),
        .add_augend(aug_m), .add_addend(addend_m), .add_cin(cin_m),
        .add_sum(sum_m), .add_carry(carry_m),
        .busy(busy_m), .done(done_m), .product(prod_m), .ovf(ovf_m)
    );

    shift_add_multiplier #(.WIDTH(16), .EARLY_EXIT(1'b1)) u_ee (
        .clk(clk), .rst_n(rst_n), .start(start_e),
        .multiplicand(mcand), .multiplier(mplier),
        .add_augend(aug_e), .add_addend(addend_e), .add_cin(cin_e),
        .add_sum(sum_e), .add_carry(carry_e),
        .busy(busy_e), .done(done_e), .product(prod_e), .ovf(ovf_e)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] prod;
        int          lat;
    } vec_t;

    vec_t vecs[8];
    vec_t ee_vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Starts one multiply on the selected instance and returns at the negedge
    // inside the done cycle; lat counts cycles from accept to done.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          input bit chk_add, output int lat);
        @(negedge clk);
        mcand  = a;
        mplier = b;
        if (use_ee) start_e = 1'b1;
        else        start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        start_e = 1'b0;
        lat = 0;
        check("busy_after_accept", {31'b0, cur_busy}, 32'd1);
        while (!cur_done && lat < 40) begin
            if (chk_add && lat < 16)
                check($sformatf("addend_k%0d", lat), addend_m,
                      b[lat] ? (32'(a) << lat) : 32'd0);
            @(negedge clk);
            lat++;
        end
        check("done_seen", {31'b0, cur_done}, 32'd1);
        check("busy_low_with_done", {31'b0, cur_busy}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        int busy_seen;
        logic [15:0] bb_a[3];
        logic [15:0] bb_b[3];
        logic [31:0] bb_p[3];

        vecs[0] = '{16'd3,      16'd5,      32'h0000000F, 16};
        vecs[1] = '{16'hFFFF,   16'hFFFF,   32'hFFFE0001, 16};
        vecs[2] = '{16'd0,      16'h1234,   32'd0,        16};
        vecs[3] = '{16'h1234,   16'd0,      32'd0,        16};
        vecs[4] = '{16'd1,      16'hFFFF,   32'h0000FFFF, 16};
        vecs[5] = '{16'h8000,   16'd2,      32'h00010000, 16};
        vecs[6] = '{16'd100,    16'd200,    32'd20000,    16};
        vecs[7] = '{16'h1234,   16'h5678,   32'd103153760, 16};

        ee_vecs[0] = '{16'h1234, 16'd1,    32'h00001234, 1};
        ee_vecs[1] = '{16'hABCD, 16'd0,    32'd0,        1};
        ee_vecs[2] = '{16'd3,    16'd5,    32'd15,       3};
        ee_vecs[3] = '{16'd5,    16'd2,    32'd10,       2};
        ee_vecs[4] = '{16'd7,    16'h8000, 32'h00038000, 16};
        ee_vecs[5] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001, 16};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy",    {31'b0, busy_m}, 32'd0);
        check("rst_done",    {31'b0, done_m}, 32'd0);
        check("rst_product", prod_m,          32'd0);
        check("rst_ovf",     {31'b0, ovf_m},  32'd0);
        check("rst_augend",  aug_m,           32'd0);
        check("rst_addend",  addend_m,        32'd0);
        check("rst_cin",     {31'b0, cin_m},  32'd0);
        rst_n = 1'b1;

        // Full-length table
        use_ee = 1'b0;
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, 1'b0, lat);
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            check($sformatf("vec%0d_product", i), prod_m, vecs[i].prod);
            check($sformatf("vec%0d_ovf", i), {31'b0, ovf_m}, 32'd0);
            @(negedge clk);
            check($sformatf("vec%0d_done_pulse", i), {31'b0, done_m}, 32'd0);
            check($sformatf("vec%0d_product_hold", i), prod_m, vecs[i].prod);
        end

        // Maximum operands, addend checked on every iteration
        run_op(16'hFFFF, 16'hFFFF, 1'b1, lat);
        check("max_product", prod_m, 32'hFFFE0001);
        check("max_ovf", {31'b0, ovf_m}, 32'd0);

        // Broken adder: carry only counts where the multiplier bit is set
        inject = 1'b1;
        run_op(16'd3, 16'd0, 1'b0, lat);
        check("inj_b0_ovf", {31'b0, ovf_m}, 32'd0);
        run_op(16'd3, 16'd5, 1'b0, lat);
        check("inj_ovf_set", {31'b0, ovf_m}, 32'd1);
        check("inj_product", prod_m, 32'd15);
        @(negedge clk);
        check("inj_ovf_sticky", {31'b0, ovf_m}, 32'd1);
        inject = 1'b0;
        run_op(16'd2, 16'd3, 1'b0, lat);
        check("ovf_cleared", {31'b0, ovf_m}, 32'd0);
        check("after_inj_product", prod_m, 32'd6);

        // Start while busy is ignored
        @(negedge clk);
        mcand = 16'd7; mplier = 16'd9; start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        repeat (4) @(negedge clk);
        mcand = 16'd2; mplier = 16'd2; start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        n = 5;
        while (!done_m && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("busy_start_latency", 32'(n), 32'd16);
        check("busy_start_product", prod_m, 32'd63);
        busy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy_m || done_m) busy_seen++;
        end
        check("busy_start_no_second", 32'(busy_seen), 32'd0);

        // Back-to-back with start held high
        bb_a[0] = 16'd3;    bb_b[0] = 16'd5;    bb_p[0] = 32'd15;
        bb_a[1] = 16'd100;  bb_b[1] = 16'd200;  bb_p[1] = 32'd20000;
        bb_a[2] = 16'hFFFF; bb_b[2] = 16'hFFFF; bb_p[2] = 32'hFFFE0001;
        @(negedge clk);
        mcand = bb_a[0]; mplier = bb_b[0]; start_m = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!done_m && n < 40);
            check($sformatf("b2b%0d_interval", k), 32'(n), 32'd17);
            check($sformatf("b2b%0d_product", k), prod_m, bb_p[k]);
            if (k < 2) begin
                mcand = bb_a[k+1]; mplier = bb_b[k+1];
            end else begin
                start_m = 1'b0;
            end
        end
        @(negedge clk);
        check("b2b_idle_after", {31'b0, busy_m}, 32'd0);

        // Reset in the middle of an operation
        @(negedge clk);
        mcand = 16'd100; mplier = 16'd200; start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        repeat (8) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_busy",    {31'b0, busy_m}, 32'd0);
        check("midrst_done",    {31'b0, done_m}, 32'd0);
        check("midrst_product", prod_m,          32'd0);
        check("midrst_ovf",     {31'b0, ovf_m},  32'd0);
        check("midrst_augend",  aug_m,           32'd0);
        check("midrst_addend",  addend_m,        32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        busy_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy_m || done_m) busy_seen++;
        end
        check("midrst_aborted", 32'(busy_seen), 32'd0);
        check("midrst_product_still0", prod_m, 32'd0);
        run_op(16'd100, 16'd200, 1'b0, lat);
        check("postrst_latency", 32'(lat), 32'd16);
        check("postrst_product", prod_m, 32'd20000);

        // Early-exit instance
        use_ee = 1'b1;
        for (int i = 0; i < 6; i++) begin
            run_op(ee_vecs[i].a, ee_vecs[i].b, 1'b0, lat);
            check($sformatf("ee%0d_latency", i), 32'(lat), 32'(ee_vecs[i].lat));
            check($sformatf("ee%0d_product", i), cur_prod, ee_vecs[i].prod);
            check($sformatf("ee%0d_ovf", i), {31'b0, cur_ovf}, 32'd0);
            @(negedge clk);
            check($sformatf("ee%0d_done_pulse", i), {31'b0, cur_done}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
